cpu_bus_memory: RTL

- 64 x 4-bit bus-slave memory that sits directly downstream of the 4-bit accumulator CPU tile.
- Consumes the CPU's 6-bit address/data bus and write-cycle flag, and returns the 4-bit read nibble the CPU samples on its next edge.
- Includes a sequential program-load port so a host can fill memory before releasing the CPU.

---
 rtl/cpu_bus_pkg.sv | 26 ++
 rtl/cpu_bus_memory_array.sv | 25 ++
 rtl/cpu_bus_memory.sv | 112 +++++++++++
 3 files changed

// File: rtl/cpu_bus_pkg.sv
// Shared definitions for the accumulator CPU bus and its memory slave.
package cpu_bus_pkg;
  localparam int ADDR_W_DEF = 6;
  localparam int DATA_W_DEF = 4;

  // Bus bit fields as seen from the CPU tile: {wcyc, addr[5:0]}
  localparam int BUS_WCYC_BIT = 6;
  localparam int BUS_ADDR_MSB = 5;
  localparam int BUS_ADDR_LSB = 0;

  typedef enum logic [1:0] {
    S_READ  = 2'd0,
    S_WDATA = 2'd1,
    S_PROG  = 2'd2
  } state_t;

  // Opcodes decoded by the CPU tile
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_STA = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_JMP = 4'h5;
  localparam logic [3:0] OP_JZ  = 4'h6;
  localparam logic [3:0] OP_HLT = 4'hF;
endpackage

// File: rtl/cpu_bus_memory_array.sv
// Reset-clearable register file: one synchronous write port, one async read port.
module cpu_bus_memory_array #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst_p,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);
  logic [DATA_W-1:0] r_mem [2**ADDR_W];

  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      for (int i = 0; i < 2**ADDR_W; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/cpu_bus_memory.sv
// 64x4 bus-slave memory for the accumulator CPU with a sequential host load port.
// Optional macro CPU_BUS_MEMORY_ROM_LOW_EN makes the lower half read-only to the CPU.
module cpu_bus_memory
  import cpu_bus_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_p,
  input  logic [ADDR_W-1:0] bus_ad,
  input  logic              bus_wcyc,
  output logic [DATA_W-1:0] data_out,
  input  logic              prog_en,
  input  logic [DATA_W-1:0] prog_din,
  output logic [ADDR_W-1:0] prog_addr,
  output logic              wr_abort
);
  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_addr_q, w_addr_nxt;
  logic [ADDR_W-1:0] r_waddr_q, w_waddr_nxt;
  logic [ADDR_W-1:0] r_prog_addr, w_prog_addr_nxt;
  logic              r_wr_abort, w_abort_set;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;

  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      r_state     <= S_READ;
      r_addr_q    <= '0;
      r_waddr_q   <= '0;
      r_prog_addr <= '0;
      r_wr_abort  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_addr_q    <= w_addr_nxt;
      r_waddr_q   <= w_waddr_nxt;
      r_prog_addr <= w_prog_addr_nxt;
      r_wr_abort  <= r_wr_abort | w_abort_set;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_addr_nxt      = r_addr_q;
    w_waddr_nxt     = r_waddr_q;
    w_prog_addr_nxt = r_prog_addr;
    w_abort_set     = 1'b0;
    w_we            = 1'b0;
    w_waddr         = r_waddr_q;
    w_wdata         = bus_ad[DATA_W-1:0];
    // Load mode owns the write port from the very first prog_en edge, so
    // N cycles of prog_en load exactly N words starting at prog_addr.
    if (prog_en) begin
      w_state_nxt     = S_PROG;
      w_we            = 1'b1;
      w_waddr         = r_prog_addr;
      w_wdata         = prog_din;
      w_prog_addr_nxt = r_prog_addr + 1'b1;
      w_addr_nxt      = '0;
      w_abort_set     = (r_state == S_WDATA);
    end else begin
      case (r_state)
        S_READ: begin
          if (bus_wcyc) begin
            w_waddr_nxt = bus_ad;
            w_state_nxt = S_WDATA;
          end else begin
            w_addr_nxt = bus_ad;
          end
        end
        S_WDATA: begin
          w_state_nxt = S_READ;
          if (bus_wcyc) begin
`ifdef CPU_BUS_MEMORY_ROM_LOW_EN
            w_we        = r_waddr_q[ADDR_W-1];
            w_abort_set = !r_waddr_q[ADDR_W-1];
`else
            w_we = 1'b1;
`endif
          end else begin
            w_abort_set = 1'b1;
            w_addr_nxt  = bus_ad;
          end
        end
        S_PROG: begin
          w_state_nxt     = S_READ;
          w_prog_addr_nxt = '0;
          w_addr_nxt      = '0;
        end
        default: w_state_nxt = S_READ;
      endcase
    end
  end

  cpu_bus_memory_array #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_array (
    .clk    (clk),
    .rst_p  (rst_p),
    .i_we   (w_we),
    .i_waddr(w_waddr),
    .i_wdata(w_wdata),
    .i_raddr(r_addr_q),
    .o_rdata(data_out)
  );

  assign prog_addr = r_prog_addr;
  assign wr_abort  = r_wr_abort;
endmodule
